// File: rtl/fifo_in_pkg.sv
// Shared constants for the fitter input buffer: SVT word layout, default
// FIFO geometry and hold thresholds, and the occupancy update encoding.
package fifo_in_pkg;

    localparam int SVT_WORD_W   = 21;
    localparam int FLAG_EP      = SVT_WORD_W;
    localparam int FLAG_EE      = SVT_WORD_W + 1;
    localparam int STORE_W      = SVT_WORD_W + 2;

    localparam int DEF_ADDR_W   = 9;
    localparam int DEF_HOLD_ON  = 384;
    localparam int DEF_HOLD_OFF = 256;
    localparam int DEF_DROP_W   = 16;

    // {increment, decrement} request pair applied to an up/down counter
    typedef enum logic [1:0] {
        OCC_IDLE = 2'b00,
        OCC_DEC  = 2'b01,
        OCC_INC  = 2'b10,
        OCC_BOTH = 2'b11
    } occ_op_e;

endpackage

// File: rtl/fifo_in_ram.sv
// Simple dual-port storage: synchronous write, registered synchronous read
// with a resettable output register so the read data is clean after reset.
module fifo_in_ram
    import fifo_in_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORD_W = STORE_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem_r [0:DEPTH-1];
    logic [WORD_W-1:0] rdata_r;

    // storage array write port; contents are never reset
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // read port output register, holds its value between reads
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/fifo_in_buffer.sv
// Fitter input FIFO: stores SVT words with ep/ee flags, applies the hold FSM
// veto, raises hysteretic hold backpressure and tracks events and drops.
module fifo_in_buffer
    import fifo_in_pkg::*;
#(
    parameter int DATA_W   = SVT_WORD_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int HOLD_ON  = DEF_HOLD_ON,
    parameter int HOLD_OFF = DEF_HOLD_OFF,
    parameter int DROP_W   = DEF_DROP_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_ep,
    input  logic              din_ee,
    input  logic              din_valid,
    input  logic              veto,
    output logic              hold,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_ep,
    output logic              dout_ee,
    output logic              dout_valid,
    output logic              empty,
    output logic              full,
    output logic              ev_avail,
    output logic [ADDR_W:0]   ev_count,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              overflow
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CNT_W  = ADDR_W + 1;
    localparam int WORD_W = DATA_W + 2;

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] HOLD_ON_C  = CNT_W'(HOLD_ON);
    localparam logic [CNT_W-1:0] HOLD_OFF_C = CNT_W'(HOLD_OFF);

    logic [ADDR_W-1:0] wptr_r;
    logic [ADDR_W-1:0] rptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [CNT_W-1:0]  ev_count_r;
    logic [CNT_W-1:0]  ev_nxt_s;
    logic              empty_r;
    logic              full_r;
    logic              ev_avail_r;
    logic              hold_r;
    logic              overflow_r;
    logic              dout_valid_r;
    logic [DROP_W-1:0] drop_r;

    logic              wr_s;
    logic              rd_s;
    logic              ev_inc_s;
    logic              ev_dec_s;
    logic [WORD_W-1:0] ram_wdata_s;
    logic [WORD_W-1:0] ram_rdata_s;

    // ee flags shadowed in flops so the event count can drop on the read cycle
    logic              ee_mem_r [0:DEPTH-1];

    assign wr_s        = din_valid & ~veto & ~full_r;
    assign rd_s        = rd_en & ~empty_r;
    assign ev_inc_s    = wr_s & din_ee;
    assign ev_dec_s    = rd_s & ee_mem_r[rptr_r];
    assign ram_wdata_s = {din_ee, din_ep, din};

    fifo_in_ram #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (wr_s),
        .waddr (wptr_r),
        .wdata (ram_wdata_s),
        .re    (rd_s),
        .raddr (rptr_r),
        .rdata (ram_rdata_s)
    );

    // next occupancy from the accepted write/read pair
    always_comb begin
        count_nxt_s = count_r;
        case (occ_op_e'({wr_s, rd_s}))
            OCC_INC: count_nxt_s = count_r + CNT_W'(1);
            OCC_DEC: count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // next stored-event count from ee words entering and leaving
    always_comb begin
        ev_nxt_s = ev_count_r;
        case (occ_op_e'({ev_inc_s, ev_dec_s}))
            OCC_INC: ev_nxt_s = ev_count_r + CNT_W'(1);
            OCC_DEC: ev_nxt_s = ev_count_r - CNT_W'(1);
            default: ev_nxt_s = ev_count_r;
        endcase
    end

    // ee shadow array write port
    always_ff @(posedge clock) begin
        if (wr_s) begin
            ee_mem_r[wptr_r] <= din_ee;
        end
    end

    // pointers, counters, status flags and hold hysteresis
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_r       <= '0;
            rptr_r       <= '0;
            count_r      <= '0;
            ev_count_r   <= '0;
            empty_r      <= 1'b1;
            full_r       <= 1'b0;
            ev_avail_r   <= 1'b0;
            hold_r       <= 1'b0;
            overflow_r   <= 1'b0;
            dout_valid_r <= 1'b0;
            drop_r       <= '0;
        end else begin
            if (wr_s) begin
                wptr_r <= wptr_r + ADDR_W'(1);
            end
            if (rd_s) begin
                rptr_r <= rptr_r + ADDR_W'(1);
            end
            count_r      <= count_nxt_s;
            ev_count_r   <= ev_nxt_s;
            empty_r      <= (count_nxt_s == CNT_W'(0));
            full_r       <= (count_nxt_s == DEPTH_C);
            ev_avail_r   <= (ev_nxt_s != CNT_W'(0));
            dout_valid_r <= rd_s;
            if (din_valid && veto && (drop_r != {DROP_W{1'b1}})) begin
                drop_r <= drop_r + DROP_W'(1);
            end
            if (din_valid && !veto && full_r) begin
                overflow_r <= 1'b1;
            end
            // between the thresholds hold keeps its previous value
            if (count_nxt_s >= HOLD_ON_C) begin
                hold_r <= 1'b1;
            end else if (count_nxt_s <= HOLD_OFF_C) begin
                hold_r <= 1'b0;
            end
        end
    end

    assign dout       = ram_rdata_s[DATA_W-1:0];
    assign dout_ep    = ram_rdata_s[FLAG_EP];
    assign dout_ee    = ram_rdata_s[FLAG_EE];
    assign dout_valid = dout_valid_r;
    assign empty      = empty_r;
    assign full       = full_r;
    assign ev_avail   = ev_avail_r;
    assign ev_count   = ev_count_r;
    assign hold       = hold_r;
    assign drop_cnt   = drop_r;
    assign overflow   = overflow_r;

endmodule
